// File: rtl/run_event_counter_pkg.sv
// ----------------------------------------------------------------------------
// run_event_counter_pkg
// Shared definitions for the run event counter:
//   - bcd2_t / seg_t   : tally and segment-vector types
//   - run_kind_e       : classification of a detected run (zeros / ones)
//   - SEG_*            : lit-segment patterns {g..a} for digits 0-9 and blank
//   - BCD_MAX          : largest 2-digit BCD tally (99)
//   - RESET_ACTIVE     : level of the reset input that clears all state
//   - seg_lit()        : digit -> lit-segment pattern (codes > 9 give blank)
//   - bcd2_bump()      : 2-digit BCD increment with saturate/wrap choice
// ----------------------------------------------------------------------------
package run_event_counter_pkg;

    typedef logic [7:0] bcd2_t;
    typedef logic [6:0] seg_t;

    typedef enum logic {
        RUN_ZERO = 1'b0,
        RUN_ONE  = 1'b1
    } run_kind_e;

    localparam bcd2_t BCD_MAX      = 8'h99;
    localparam logic  RESET_ACTIVE = 1'b0;

    // Patterns are "1 = segment lit"; the decoder inverts for active-low boards.
    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;

    function automatic seg_t seg_lit(input logic [3:0] digit);
        seg_t lit;
        case (digit)
            4'd0:    lit = SEG_0;
            4'd1:    lit = SEG_1;
            4'd2:    lit = SEG_2;
            4'd3:    lit = SEG_3;
            4'd4:    lit = SEG_4;
            4'd5:    lit = SEG_5;
            4'd6:    lit = SEG_6;
            4'd7:    lit = SEG_7;
            4'd8:    lit = SEG_8;
            4'd9:    lit = SEG_9;
            default: lit = SEG_BLANK;
        endcase
        return lit;
    endfunction

    // Returns {wrapped, next_value}. wrapped is 1 only when 99 rolls to 00.
    function automatic logic [8:0] bcd2_bump(input bcd2_t value, input logic saturate);
        logic [8:0] result;
        if (value == BCD_MAX) begin
            if (saturate) begin
                result = {1'b0, BCD_MAX};
            end else begin
                result = {1'b1, 8'h00};
            end
        end else if (value[3:0] == 4'd9) begin
            result = {1'b0, value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {1'b0, value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/run_event_counter_if.sv
// ----------------------------------------------------------------------------
// run_event_counter_if
// Signal bundle between the run event counter and its environment.
//   master : drives det_in, w_in, clr, hold; observes tallies, flags, digits
//   slave  : the counter itself (the reverse directions)
// ----------------------------------------------------------------------------
interface run_event_counter_if;
    import run_event_counter_pkg::*;

    logic  det_in;
    logic  w_in;
    logic  clr;
    logic  hold;
    bcd2_t zeros_bcd;
    bcd2_t ones_bcd;
    logic  ovf_zero;
    logic  ovf_one;
    logic  evt_pulse;
    seg_t  hex0;
    seg_t  hex1;
    seg_t  hex2;
    seg_t  hex3;

    modport master (
        output det_in, w_in, clr, hold,
        input  zeros_bcd, ones_bcd, ovf_zero, ovf_one, evt_pulse,
        input  hex0, hex1, hex2, hex3
    );

    modport slave (
        input  det_in, w_in, clr, hold,
        output zeros_bcd, ones_bcd, ovf_zero, ovf_one, evt_pulse,
        output hex0, hex1, hex2, hex3
    );
endinterface

// File: rtl/run_event_counter_bcd_to_7seg.sv
// ----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational single-digit decoder for the lab board.
//   bcd : 4-bit digit (0-9; anything else is shown blank)
//   seg : segments {g..a}, polarity chosen by SEG_ACTIVE_LOW
// ----------------------------------------------------------------------------
module bcd_to_7seg
    import run_event_counter_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd,
    output seg_t       seg
);

    seg_t lit_s;

    // Look up the lit pattern and apply the board's drive polarity.
    always_comb begin
        lit_s = seg_lit(bcd);
        if (SEG_ACTIVE_LOW) begin
            seg = ~lit_s;
        end else begin
            seg = lit_s;
        end
    end

endmodule

// File: rtl/run_event_counter.sv
// ----------------------------------------------------------------------------
// run_event_counter
// Counts rising edges of the run detector output, classifying each as a
// zero-run or one-run by the serial bit that completed the run, and shows
// both 2-digit BCD tallies on four seven-segment digits.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low; clears all state immediately
//   bus    : slave side of run_event_counter_if
//            in : det_in (detector level), w_in (serial bit), clr, hold
//            out: zeros_bcd, ones_bcd, ovf_zero, ovf_one, evt_pulse,
//                 hex0/hex1 (ones units/tens), hex2/hex3 (zeros units/tens)
// ----------------------------------------------------------------------------
module run_event_counter
    import run_event_counter_pkg::*;
#(
    parameter bit SATURATE       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic              clk,
    input logic              reset,
    run_event_counter_if.slave bus
);

    logic       det_q_r;
    logic       w_q_r;
    logic       evt_s;
    run_kind_e  kind_s;

    bcd2_t      zeros_r;
    bcd2_t      ones_r;
    logic       ovf_zero_r;
    logic       ovf_one_r;
    logic       evt_pulse_r;
    bcd2_t      disp_zeros_r;
    bcd2_t      disp_ones_r;

    bcd2_t      zeros_nxt_s;
    bcd2_t      ones_nxt_s;
    logic       ovf_zero_nxt_s;
    logic       ovf_one_nxt_s;
    logic       evt_pulse_nxt_s;
    logic [8:0] zeros_bump_s;
    logic [8:0] ones_bump_s;

    seg_t       hex0_s;
    seg_t       hex1_s;
    seg_t       hex2_s;
    seg_t       hex3_s;

    // det_q resets high so a detector that is already high at release is ignored.
    assign evt_s  = bus.det_in & ~det_q_r;
    // The detector output lags its input bit by one cycle, so the registered
    // bit (not the live one) is what completed the run.
    assign kind_s = run_kind_e'(w_q_r);

    assign zeros_bump_s = bcd2_bump(zeros_r, SATURATE);
    assign ones_bump_s  = bcd2_bump(ones_r, SATURATE);

    // Input history registers: previous detector level and serial bit.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            det_q_r <= 1'b1;
            w_q_r   <= 1'b0;
        end else begin
            det_q_r <= bus.det_in;
            w_q_r   <= bus.w_in;
        end
    end

    // Next-state of the tallies, overflow flags and event pulse; clr beats an event.
    always_comb begin
        zeros_nxt_s     = zeros_r;
        ones_nxt_s      = ones_r;
        ovf_zero_nxt_s  = ovf_zero_r;
        ovf_one_nxt_s   = ovf_one_r;
        evt_pulse_nxt_s = 1'b0;
        if (bus.clr) begin
            zeros_nxt_s    = 8'h00;
            ones_nxt_s     = 8'h00;
            ovf_zero_nxt_s = 1'b0;
            ovf_one_nxt_s  = 1'b0;
        end else if (evt_s) begin
            evt_pulse_nxt_s = 1'b1;
            case (kind_s)
                RUN_ZERO: begin
                    zeros_nxt_s    = zeros_bump_s[7:0];
                    ovf_zero_nxt_s = ovf_zero_r | zeros_bump_s[8];
                end
                RUN_ONE: begin
                    ones_nxt_s    = ones_bump_s[7:0];
                    ovf_one_nxt_s = ovf_one_r | ones_bump_s[8];
                end
                default: begin
                    zeros_nxt_s = zeros_r;
                    ones_nxt_s  = ones_r;
                end
            endcase
        end else begin
            evt_pulse_nxt_s = 1'b0;
        end
    end

    // Tally, overflow and event-pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            zeros_r     <= 8'h00;
            ones_r      <= 8'h00;
            ovf_zero_r  <= 1'b0;
            ovf_one_r   <= 1'b0;
            evt_pulse_r <= 1'b0;
        end else begin
            zeros_r     <= zeros_nxt_s;
            ones_r      <= ones_nxt_s;
            ovf_zero_r  <= ovf_zero_nxt_s;
            ovf_one_r   <= ovf_one_nxt_s;
            evt_pulse_r <= evt_pulse_nxt_s;
        end
    end

    // Display copies trail the tallies by one edge and freeze while hold is high.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            disp_zeros_r <= 8'h00;
            disp_ones_r  <= 8'h00;
        end else if (bus.hold) begin
            disp_zeros_r <= disp_zeros_r;
            disp_ones_r  <= disp_ones_r;
        end else begin
            disp_zeros_r <= zeros_r;
            disp_ones_r  <= ones_r;
        end
    end

    bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex0 (.bcd(disp_ones_r[3:0]),  .seg(hex0_s));
    bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex1 (.bcd(disp_ones_r[7:4]),  .seg(hex1_s));
    bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex2 (.bcd(disp_zeros_r[3:0]), .seg(hex2_s));
    bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex3 (.bcd(disp_zeros_r[7:4]), .seg(hex3_s));

    assign bus.zeros_bcd = zeros_r;
    assign bus.ones_bcd  = ones_r;
    assign bus.ovf_zero  = ovf_zero_r;
    assign bus.ovf_one   = ovf_one_r;
    assign bus.evt_pulse = evt_pulse_r;
    assign bus.hex0      = hex0_s;
    assign bus.hex1      = hex1_s;
    assign bus.hex2      = hex2_s;
    assign bus.hex3      = hex3_s;

endmodule

// File: tb/tb_run_event_counter.sv
// ----------------------------------------------------------------------------
// tb_run_event_counter
// Two counters share one stimulus stream: one saturating with active-low
// segments, one wrapping with active-high segments. Expected values come from
// integer event counts kept by the bench, converted to BCD and segment codes.
// ----------------------------------------------------------------------------
module tb_run_event_counter;

    logic clk;
    logic reset_v;
    logic w_v;
    logic det_v;
    logic use_det;
    logic clr_v;
    logic hold_v;

    // Upstream run detector: high after four equal consecutive bits.
    logic [3:0] hist_r;
    logic       det_m_r;

    int checks = 0;
    int errors = 0;
    int n_zero = 0;
    int n_one  = 0;
    int disp_nz = 0;
    int disp_no = 0;

    localparam logic [6:0] SEG_AL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    run_event_counter_if bus_s();
    run_event_counter_if bus_w();

    run_event_counter #(.SATURATE(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_sat (
        .clk(clk), .reset(reset_v), .bus(bus_s));
    run_event_counter #(.SATURATE(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_wrap (
        .clk(clk), .reset(reset_v), .bus(bus_w));

    assign bus_s.det_in = use_det ? det_m_r : det_v;
    assign bus_w.det_in = use_det ? det_m_r : det_v;
    assign bus_s.w_in   = w_v;
    assign bus_w.w_in   = w_v;
    assign bus_s.clr    = clr_v;
    assign bus_w.clr    = clr_v;
    assign bus_s.hold   = hold_v;
    assign bus_w.hold   = hold_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural run detector feeding det_in when use_det is set.
    always @(posedge clk or negedge reset_v) begin
        if (!reset_v) begin
            hist_r  <= 4'b0101;
            det_m_r <= 1'b0;
        end else begin
            hist_r  <= {hist_r[2:0], w_v};
            det_m_r <= ({hist_r[2:0], w_v} == 4'b0000) || ({hist_r[2:0], w_v} == 4'b1111);
        end
    end

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [7:0] exp_sat(input int n);
        return to_bcd((n > 99) ? 99 : n);
    endfunction

    function automatic logic [7:0] exp_wrap(input int n);
        return to_bcd(n % 100);
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d, input bit active_low);
        return active_low ? SEG_AL[d] : ~SEG_AL[d];
    endfunction

    function automatic logic [27:0] hex_exp(input logic [7:0] z, input logic [7:0] o, input bit al);
        return {seg(z[7:4], al), seg(z[3:0], al), seg(o[7:4], al), seg(o[3:0], al)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_tallies(input string tag);
        chk({tag, " sat zeros"}, 32'(bus_s.zeros_bcd), 32'(exp_sat(n_zero)));
        chk({tag, " sat ones"},  32'(bus_s.ones_bcd),  32'(exp_sat(n_one)));
        chk({tag, " sat ovf"},   32'({bus_s.ovf_zero, bus_s.ovf_one}), 32'(2'b00));
        chk({tag, " wrap zeros"}, 32'(bus_w.zeros_bcd), 32'(exp_wrap(n_zero)));
        chk({tag, " wrap ones"},  32'(bus_w.ones_bcd),  32'(exp_wrap(n_one)));
        chk({tag, " wrap ovf"},   32'({bus_w.ovf_zero, bus_w.ovf_one}),
            32'({n_zero >= 100, n_one >= 100}));
    endtask

    task automatic check_display(input string tag);
        chk({tag, " sat hex"}, 32'({bus_s.hex3, bus_s.hex2, bus_s.hex1, bus_s.hex0}),
            32'(hex_exp(exp_sat(disp_nz), exp_sat(disp_no), 1'b1)));
        chk({tag, " wrap hex"}, 32'({bus_w.hex3, bus_w.hex2, bus_w.hex1, bus_w.hex0}),
            32'(hex_exp(exp_wrap(disp_nz), exp_wrap(disp_no), 1'b0)));
    endtask

    task automatic check_pulse(input string tag, input logic exp_p);
        chk({tag, " sat pulse"},  32'(bus_s.evt_pulse), 32'(exp_p));
        chk({tag, " wrap pulse"}, 32'(bus_w.evt_pulse), 32'(exp_p));
    endtask

    // One event: det low with the classifying bit, then det high (optionally with clr).
    task automatic do_event(input logic b, input logic with_clr, input string tag);
        det_v = 1'b0;
        w_v   = b;
        tick();
        det_v = 1'b1;
        w_v   = 1'($urandom);
        clr_v = with_clr;
        tick();
        check_pulse(tag, !with_clr);
        clr_v = 1'b0;
        det_v = 1'b0;
        if (with_clr) begin
            n_zero = 0;
            n_one  = 0;
        end else if (b) begin
            n_one++;
        end else begin
            n_zero++;
        end
    endtask

    initial begin
        reset_v = 1'b0;
        w_v     = 1'b0;
        det_v   = 1'b0;
        use_det = 1'b0;
        clr_v   = 1'b0;
        hold_v  = 1'b0;

        // Reset state
        repeat (3) tick();
        check_tallies("reset");
        check_pulse("reset", 1'b0);
        check_display("reset");
        reset_v = 1'b1;

        // Detector attached: five zeros, then six ones
        use_det = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            w_v = (i <= 5) ? 1'b0 : ((i <= 11) ? 1'b1 : 1'b0);
            tick();
            if (i == 5) begin
                n_zero = 1;
                check_tallies("zero run");
                check_pulse("zero run", 1'b1);
            end
            if (i == 6) begin
                disp_nz = 1;
                check_pulse("zero run after", 1'b0);
                check_display("zero run disp");
            end
            if (i == 10) begin
                n_one = 1;
                check_pulse("one run", 1'b1);
            end
            if (i == 11) begin
                check_pulse("one run after", 1'b0);
            end
        end
        check_tallies("long one run");
        use_det = 1'b0;

        // Push the one tally to 100 events, then one more
        for (int i = 0; i < 99; i++) begin
            do_event(1'b1, 1'b0, "ones fill");
        end
        check_tallies("ones 100");
        do_event(1'b1, 1'b0, "ones 101");
        check_tallies("ones 101");

        // Random mix of events
        for (int i = 0; i < 40; i++) begin
            do_event(1'($urandom), 1'b0, "random");
            check_tallies("random");
            if ($urandom_range(0, 3) == 0) begin
                tick();
            end
        end
        tick();
        disp_nz = n_zero;
        disp_no = n_one;
        check_display("random disp");

        // Clear, then zero-run carry from 09 to 10, then clr colliding with an event
        clr_v = 1'b1;
        tick();
        clr_v  = 1'b0;
        n_zero = 0;
        n_one  = 0;
        check_tallies("clr");
        for (int i = 0; i < 9; i++) begin
            do_event(1'b0, 1'b0, "zeros fill");
        end
        check_tallies("zeros 09");
        do_event(1'b0, 1'b0, "zeros 10");
        check_tallies("zeros 10");
        do_event(1'b0, 1'b1, "clr with event");
        check_tallies("clr with event");
        tick();
        check_pulse("clr with event after", 1'b0);

        // Hold freezes the display while counting continues
        do_event(1'b1, 1'b0, "pre hold");
        tick();
        disp_nz = n_zero;
        disp_no = n_one;
        check_display("pre hold");
        hold_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_event(1'b1, 1'b0, "held");
        end
        tick();
        check_tallies("held");
        check_display("held");
        hold_v = 1'b0;
        tick();
        disp_no = n_one;
        check_display("hold release");

        // Asynchronous reset between edges, released with det_in already high
        do_event(1'b0, 1'b0, "pre reset");
        det_v   = 1'b1;
        w_v     = 1'b1;
        reset_v = 1'b0;
        #2;
        n_zero  = 0;
        n_one   = 0;
        disp_nz = 0;
        disp_no = 0;
        check_tallies("async reset");
        check_pulse("async reset", 1'b0);
        check_display("async reset");
        #2;
        reset_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_pulse("det high at release", 1'b0);
        end
        check_tallies("det high at release");
        do_event(1'b0, 1'b0, "after release");
        check_tallies("after release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_event_counter.md
Name: run_event_counter

Overview:
- Downstream consumer of the run detector. The detector raises out1 after four consecutive equal bits on w.
- This block detects each rising edge of the detector output and classifies it as a zero-run or a one-run using the serial bit that caused it.
- It keeps two 2-digit BCD tallies (00-99) and drives four seven-segment digits for the lab board.

Parameters:
- SATURATE, 1, 1: counters stop at 99. 0: counters wrap 99->00 and set that counter's overflow flag.
- SEG_ACTIVE_LOW, 1, 1: segment outputs are active-low (lit = 0). 0: active-high.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- det_in  input  1  detector output (out1), level.
- w_in  input  1  the same serial bit stream that feeds the detector, sampled on the same clk.
- clr  input  1  synchronous clear of both tallies and both overflow flags.
- hold  input  1  freeze the display registers; counting continues.
- zeros_bcd  output  8  zero-run tally: [7:4] tens, [3:0] units.
- ones_bcd  output  8  one-run tally, same format.
- ovf_zero  output  1  sticky overflow flag, zero-run tally.
- ovf_one  output  1  sticky overflow flag, one-run tally.
- evt_pulse  output  1  one-cycle pulse per counted event.
- hex0  output  7  units digit of ones_bcd (display copy), segments {g..a}.
- hex1  output  7  tens digit of ones_bcd (display copy).
- hex2  output  7  units digit of zeros_bcd (display copy).
- hex3  output  7  tens digit of zeros_bcd (display copy).

Behaviour:
- Reset (reset=0, asynchronous):
  - det_q=1, so a detector already high at release is not counted.
  - w_q=0; tallies=00; ovf flags=0; evt_pulse=0.
  - Display registers=00, so all hex outputs show "0" (7'b1000000 when active-low).
- Registers every edge: det_q <= det_in; w_q <= w_in.
  - w_q holds the bit that drove the detector's last transition.
  - The detector output rises one cycle after that bit, so w_q, not w_in, is the classifier.
- Event: evt = det_in & ~det_q, combinational.
  - A detector held high counts once only.
  - A new event needs det_in to go low for at least one cycle first.
- Counter update on the edge that samples evt=1:
  - w_q=0 increments zeros_bcd; w_q=1 increments ones_bcd.
  - evt_pulse=1 for the following cycle; otherwise evt_pulse=0.
- BCD arithmetic:
  - Units 9->0 carries into tens.
  - At 99 with SATURATE=1: value holds at 99, ovf stays 0, evt_pulse still fires.
  - At 99 with SATURATE=0: value becomes 00 and ovf is set (sticky until clr or reset).
- clr=1: both tallies=00 and both ovf=0 on the next edge.
  - clr and evt in the same cycle: clr wins and the event is discarded, so evt_pulse=0.
  - det_q/w_q still update normally.
- Display path:
  - Display registers copy the tallies one edge after a tally changes (counter-to-segment latency 2 edges from the det_in rise).
  - hold=1 freezes the display registers; tallies keep counting.
  - On hold release the display catches up on the next edge.
- Segment decode is combinational from the display registers. Digit codes >9 cannot occur; the decoder maps them to blank (all segments off).
- No output is combinational from inputs other than through registers.

Decomposition:
- Shared package: segment codes for digits 0-9 and blank, BCD_MAX=8'h99, reset-polarity constant.
- One sub-module, bcd_to_7seg: 4-bit BCD in, 7-bit segments out, SEG_ACTIVE_LOW parameter; instantiated four times.
- A bcd2_counter helper is optional; the two tallies may be inlined.

Test Plan:
- Reset, then stream w=0,0,0,0,0 with the detector attached -> det_in rises once -> zeros_bcd=8'h01, ones_bcd=8'h00, evt_pulse high exactly 1 cycle, hex2 shows "1" two edges after the det_in rise.
- w=1 x6 (det_in stays high 3 cycles) -> ones_bcd=8'h01, not 8'h03.
- 100 one-run events with SATURATE=1 -> ones_bcd=8'h99, ovf_one=0. Repeat with SATURATE=0 -> ones_bcd=8'h00, ovf_one=1.
- 9 then 10 zero-run events -> zeros_bcd 8'h09 -> 8'h10 (units carry). Assert clr on the cycle of an 11th event -> zeros_bcd=8'h00, evt_pulse=0.
- hold=1, then 3 one-run events -> hex0/hex1 unchanged, ones_bcd=8'h03. Release hold -> hex0 shows "3" on the next edge.
- Pull reset low mid-stream between edges -> all outputs clear immediately. Release with det_in=1 -> no event counted until det_in falls and rises again.
